// File: rtl/reaction_timer_if.sv
// Handshake bundle between the reaction-game state machine (master) and its
// timing datapath (slave).
interface reaction_timer_if;
  logic        downcountenable;
  logic        enableCounter;
  logic        enablehiscore;
  logic        finished;
  logic [13:0] score;
  logic [13:0] hiscore;
  logic        hiscore_valid;
  logic        new_record;
  logic [13:0] disp_value;

  modport master (
    output downcountenable, enableCounter, enablehiscore,
    input  finished, score, hiscore, hiscore_valid, new_record, disp_value
  );

  modport slave (
    input  downcountenable, enableCounter, enablehiscore,
    output finished, score, hiscore, hiscore_valid, new_record, disp_value
  );
endinterface

// File: rtl/reaction_timer_core.sv
// Reaction-game datapath: random-wait downcounter, ms reaction counter,
// best-time register and display mux.
module reaction_timer_core #(
  parameter int TICK_DIV  = 50000,
  parameter int MIN_DELAY = 1000,
  parameter int SCORE_MAX = 9999
) (
  input logic              clk,
  input logic              rst,
  reaction_timer_if.slave  bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(MIN_DELAY + 1024);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DLY_MIN = DW'(MIN_DELAY);
  localparam logic [13:0]   SC_MAX  = 14'(SCORE_MAX);

  logic          dce, ec;
  logic          dce_q, ec_q;
  logic          dce_rise, ec_rise, ec_fall;
  logic [9:0]    lfsr;
  logic [PW-1:0] prescale;
  logic          tick;
  logic [DW-1:0] delay_cnt;
  logic          finished;
  logic [13:0]   score, hiscore;
  logic          hiscore_valid, new_record;
  logic          better;

  assign dce      = bus.downcountenable;
  assign ec       = bus.enableCounter;
  assign dce_rise = dce & ~dce_q;
  assign ec_rise  = ec & ~ec_q;
  assign ec_fall  = ~ec & ec_q;
  assign tick     = (prescale == PS_LAST) & (dce | ec);
  assign better   = ~hiscore_valid | (score < hiscore);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dce_q    <= 1'b0;
      ec_q     <= 1'b0;
      lfsr     <= 10'h001;
      prescale <= '0;
    end else begin
      dce_q <= dce;
      ec_q  <= ec;
      // x^10 + x^7 + 1; the all-zero state is unreachable from a nonzero seed
      lfsr  <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      if (dce_rise || ec_rise || prescale == PS_LAST)
        prescale <= '0;
      else
        prescale <= prescale + PW'(1);
    end
  end

  // Load takes priority over a coincident tick; the load uses the pre-shift lfsr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_cnt <= '0;
      finished  <= 1'b0;
    end else begin
      if (dce_rise)
        delay_cnt <= DLY_MIN + DW'(lfsr);
      else if (tick && dce && delay_cnt != '0)
        delay_cnt <= delay_cnt - DW'(1);

      if (!dce)
        finished <= 1'b0;
      else if (!dce_rise && tick && delay_cnt == DW'(1))
        finished <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score         <= '0;
      hiscore       <= '0;
      hiscore_valid <= 1'b0;
      new_record    <= 1'b0;
    end else begin
      new_record <= 1'b0;
      if (ec_rise)
        score <= '0;
      else if (tick && ec && score < SC_MAX)
        score <= score + 14'd1;

      // A stop with enablehiscore high is an abort to idle, never a result.
      if (ec_fall && !bus.enablehiscore && better) begin
        hiscore       <= score;
        hiscore_valid <= 1'b1;
        new_record    <= 1'b1;
      end
    end
  end

  assign bus.finished      = finished;
  assign bus.score         = score;
  assign bus.hiscore       = hiscore;
  assign bus.hiscore_valid = hiscore_valid;
  assign bus.new_record    = new_record;
  assign bus.disp_value    = bus.enablehiscore ? hiscore : score;
endmodule

// File: tb/tb_reaction_timer_core.sv
// Scoreboard bench for reaction_timer_core: stimulus queues expected finished
// and new_record events, a negedge monitor pops and compares them.
module tb_reaction_timer_core;
  logic clk = 1'b0;
  logic rst = 1'b1;

  reaction_timer_if rif();

  reaction_timer_core #(.TICK_DIV(4), .MIN_DELAY(8), .SCORE_MAX(9999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [9:0] m_lfsr;

  typedef struct {
    bit is_rec;
    int val;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic fin_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 10'h001;
    else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rif.finished && !fin_prev) begin
        if (sb.size() == 0) unexpected("unexpected_finished");
        else begin
          mon_e = sb.pop_front();
          check("fin_kind", 32'(mon_e.is_rec), 0);
          if (!mon_e.is_rec) check("fin_cycle", cyc, mon_e.val);
        end
      end
      if (rif.new_record) begin
        if (sb.size() == 0) unexpected("unexpected_new_record");
        else begin
          mon_e = sb.pop_front();
          check("rec_kind", 32'(mon_e.is_rec), 1);
          if (mon_e.is_rec) begin
            check("rec_hiscore", rif.hiscore, mon_e.val);
            check("rec_valid", rif.hiscore_valid, 1);
          end
        end
      end
    end
    fin_prev = rif.finished;
  end

  task automatic wait_sb(input int limit, input string name);
    int k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending events, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Full random wait: finished must rise 4*(8+L) cycles after the load edge.
  task automatic wait_run(input string name);
    int l, e0;
    @(negedge clk);
    l  = int'(m_lfsr);
    e0 = cyc + 1;
    sb.push_back(exp_t'{is_rec: 1'b0, val: e0 + 4 * (8 + l)});
    rif.downcountenable = 1'b1;
    wait_sb(4 * (8 + l) + 20, name);
    repeat (2) @(negedge clk);
    check({name, "_hold"}, rif.finished, 1);
    rif.downcountenable = 1'b0;
    @(negedge clk);
    check({name, "_drop"}, rif.finished, 0);
  endtask

  // enableCounter high for n edges; enablehiscore is driven to hs on the falling edge.
  task automatic ec_run(input int n, input logic hs);
    @(negedge clk);
    rif.enableCounter = 1'b1;
    repeat (n) @(negedge clk);
    rif.enableCounter = 1'b0;
    rif.enablehiscore = hs;
    repeat (2) @(negedge clk);
    rif.enablehiscore = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.downcountenable = 1'b0;
    rif.enableCounter   = 1'b0;
    rif.enablehiscore   = 1'b0;
    #1;
    check("rst_finished", rif.finished, 0);
    check("rst_score", rif.score, 0);
    check("rst_hiscore_valid", rif.hiscore_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_run("wait1");

    // Abort after 10 cycles: finished must never rise.
    @(negedge clk);
    rif.downcountenable = 1'b1;
    repeat (10) @(negedge clk);
    rif.downcountenable = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_finished", rif.finished, 0);
    wait_run("reload");

    sb.push_back(exp_t'{is_rec: 1'b1, val: 9});
    ec_run(37, 1'b0);
    wait_sb(5, "rec9");
    check("run37_score", rif.score, 9);
    check("run37_hiscore", rif.hiscore, 9);
    check("run37_valid", rif.hiscore_valid, 1);

    ec_run(53, 1'b0);
    check("run13_score", rif.score, 13);
    check("run13_hiscore", rif.hiscore, 9);

    sb.push_back(exp_t'{is_rec: 1'b1, val: 5});
    ec_run(21, 1'b0);
    wait_sb(5, "rec5");
    check("run5_hiscore", rif.hiscore, 5);

    ec_run(21, 1'b0);
    check("tie_score", rif.score, 5);
    check("tie_hiscore", rif.hiscore, 5);

    ec_run(9, 1'b1);
    check("idle_abort_score", rif.score, 2);
    check("idle_abort_hiscore", rif.hiscore, 5);

    rif.enablehiscore = 1'b1;
    #1;
    check("mux_hiscore", rif.disp_value, 5);
    rif.enablehiscore = 1'b0;
    #1;
    check("mux_score", rif.disp_value, 2);

    ec_run(40100, 1'b0);
    check("sat_score", rif.score, 9999);
    check("sat_hiscore", rif.hiscore, 5);

    // Asynchronous reset in the middle of a timing run.
    @(negedge clk);
    rif.enableCounter = 1'b1;
    repeat (30) @(negedge clk);
    check("pre_rst_score", rif.score, 7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_score", rif.score, 0);
    check("arst_hiscore", rif.hiscore, 0);
    check("arst_valid", rif.hiscore_valid, 0);
    check("arst_new_record", rif.new_record, 0);
    check("arst_disp", rif.disp_value, 0);
    @(negedge clk);
    rif.enableCounter = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    wait_run("post_rst");

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
